// File: rtl/fc_argmax.sv
// Streaming argmax over NUM_CLASSES IEEE-754 single-precision FC outputs.
// Optional build macro FC_ARGMAX_RELU_EN clamps negative samples to +0 before comparison.
module fc_argmax #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned NUM_CLASSES = 10,
    parameter int unsigned IDX_WIDTH   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic [IDX_WIDTH-1:0]  class_idx,
    output logic [DATA_WIDTH-1:0] max_value,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

    localparam logic [IDX_WIDTH-1:0] LastIdx = IDX_WIDTH'(NUM_CLASSES - 1);

    state_e                state_q, state_d;
    logic [IDX_WIDTH-1:0]  cnt_q, cnt_d;
    logic [IDX_WIDTH-1:0]  idx_q, idx_d;
    logic [DATA_WIDTH-1:0] max_q, max_d;
    logic [DATA_WIDTH-1:0] sample;
    logic                  is_nan;
    logic                  greater;

    // Maps a float onto an unsigned key with the same ordering; -0 folds onto +0.
    function automatic logic [DATA_WIDTH-1:0] order_key(input logic [DATA_WIDTH-1:0] v);
        logic [DATA_WIDTH-2:0] mag;
        mag = v[DATA_WIDTH-2:0];
        if (v[DATA_WIDTH-1] && (mag != '0)) begin
            return {1'b0, ~mag};
        end
        return {1'b1, mag};
    endfunction

`ifdef FC_ARGMAX_RELU_EN
    assign sample = in_data[DATA_WIDTH-1] ? '0 : in_data;
`else
    assign sample = in_data;
`endif

    assign is_nan  = (sample[30:23] == 8'hFF) && (sample[22:0] != '0);
    assign greater = order_key(sample) > order_key(max_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        max_d   = max_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StAccum;
                    cnt_d   = '0;
                    idx_d   = '0;
                    max_d   = '0;
                end
            end
            StAccum: begin
                // A start here restarts the run and drops any same-cycle sample.
                if (start) begin
                    cnt_d = '0;
                    idx_d = '0;
                    max_d = '0;
                end else if (in_valid) begin
                    if ((cnt_q == '0) || (greater && !is_nan)) begin
                        idx_d = cnt_q;
                        max_d = sample;
                    end
                    if (cnt_q == LastIdx) begin
                        state_d = StDone;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            max_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            max_q   <= max_d;
        end
    end

    assign in_ready  = (state_q == StAccum);
    assign busy      = (state_q == StAccum);
    assign done      = (state_q == StDone);
    assign class_idx = idx_q;
    assign max_value = max_q;

endmodule

// File: tb/tb_fc_argmax.sv
// Bench for fc_argmax: vector table plus hand sequences, results checked through a scoreboard.
module tb_fc_argmax;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic [3:0]  class_idx;
    logic [31:0] max_value;
    logic        busy;
    logic        done;

    fc_argmax #(
        .DATA_WIDTH (32),
        .NUM_CLASSES(10),
        .IDX_WIDTH  (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .class_idx(class_idx),
        .max_value(max_value),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [9:0][31:0] s;
        logic [3:0]       idx;
        logic [31:0]      mx;
        logic             gap;
    } vec_t;

    typedef struct packed {
        logic [3:0]  idx;
        logic [31:0] mx;
    } exp_t;

    vec_t vecs [9];
    exp_t sb [$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   last_acc = -100;
    logic prev_done = 1'b0;

    function automatic vec_t mk(input logic [31:0] fill, input int pos, input logic [31:0] val,
                                input logic [3:0] idx, input logic [31:0] mx, input logic gap);
        vec_t v;
        for (int k = 0; k < 10; k++) v.s[k] = fill;
        v.s[pos] = val;
        v.idx    = idx;
        v.mx     = mx;
        v.gap    = gap;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // One clock: sample at the falling edge, then return 1 time unit after the rising edge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (in_valid && in_ready && !start && !reset) last_acc = cyc;
        if (done) begin
            check("done_width", {31'd0, prev_done}, 32'd0);
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL spurious_done: got done=1 at cycle %0d expected none", cyc);
            end else begin
                e = sb.pop_front();
                check("class_idx", {28'd0, class_idx}, {28'd0, e.idx});
                check("max_value", max_value, e.mx);
                check("done_latency", cyc - last_acc, 32'd1);
            end
        end
        prev_done = done;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic feed(input vec_t v, input int first, input int last);
        for (int k = first; k <= last; k++) begin
            in_valid = 1'b1;
            in_data  = v.s[k];
            tick();
            if (v.gap) begin
                in_valid = 1'b0;
                in_data  = $urandom;
                tick();
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        for (int n = 0; n < 20 && sb.size() != 0; n++) tick();
        if (sb.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL done_timeout: got no done within 20 cycles expected done");
            sb.delete();
        end
    endtask

    task automatic begin_run(input vec_t v, input logic push);
        start = 1'b1;
        if (push) sb.push_back({v.idx, v.mx});
        tick();
        start = 1'b0;
    endtask

    initial begin
        vec_t big;
        logic [3:0] hold_idx;
        logic [31:0] hold_max;

        vecs[0] = mk(32'h3F800000, 6, 32'h40000000, 4'd6, 32'h40000000, 1'b0);
        vecs[1] = mk(32'h3F000000, 0, 32'h3F000000, 4'd0, 32'h3F000000, 1'b0);
`ifdef FC_ARGMAX_RELU_EN
        vecs[2] = mk(32'hC0400000, 3, 32'hBF800000, 4'd0, 32'h00000000, 1'b0);
        vecs[7] = mk(32'h00000000, 0, 32'h80000000, 4'd0, 32'h00000000, 1'b0);
`else
        vecs[2] = mk(32'hC0400000, 3, 32'hBF800000, 4'd3, 32'hBF800000, 1'b0);
        vecs[7] = mk(32'h00000000, 0, 32'h80000000, 4'd0, 32'h80000000, 1'b0);
`endif
        vecs[3] = mk(32'h3F800000, 6, 32'h40000000, 4'd6, 32'h40000000, 1'b1);
        vecs[4] = mk(32'h3F800000, 2, 32'h7FC00000, 4'd0, 32'h3F800000, 1'b0);
        vecs[5] = mk(32'hBF000000, 5, 32'h3DCCCCCD, 4'd5, 32'h3DCCCCCD, 1'b0);
        vecs[6] = mk(32'h3F800000, 9, 32'h7F7FFFFF, 4'd9, 32'h7F7FFFFF, 1'b0);
        vecs[8] = mk(32'h80000000, 4, 32'h00800000, 4'd4, 32'h00800000, 1'b0);
        big     = mk(32'h7F000000, 0, 32'h7F000000, 4'd0, 32'h7F000000, 1'b0);

        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        tick();
        tick();
        reset = 1'b0;
        check("rst_class_idx", {28'd0, class_idx}, 32'd0);
        check("rst_max_value", max_value, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);

        for (int i = 0; i < 9; i++) begin
            begin_run(vecs[i], 1'b1);
            check("busy_in_accum", {31'd0, busy}, 32'd1);
            feed(vecs[i], 0, 9);
            if (i == 0) begin
                // Start during the done cycle must be ignored.
                start = 1'b1;
                tick();
                start = 1'b0;
                check("start_in_done_busy", {31'd0, busy}, 32'd0);
                check("start_in_done_ready", {31'd0, in_ready}, 32'd0);
                hold_idx = class_idx;
                hold_max = max_value;
                in_valid = 1'b1;
                in_data  = 32'h7F7FFFFF;
                for (int n = 0; n < 3; n++) tick();
                in_valid = 1'b0;
                check("hold_class_idx", {28'd0, class_idx}, {28'd0, vecs[0].idx});
                check("hold_max_value", max_value, vecs[0].mx);
                check("hold_stable_idx", {28'd0, class_idx}, {28'd0, hold_idx});
                check("hold_stable_max", max_value, hold_max);
            end else begin
                wait_done();
            end
        end

        // Reset after sample 4 discards the run; reset beats start and in_valid.
        begin_run(big, 1'b0);
        feed(big, 0, 4);
        reset    = 1'b1;
        start    = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'h7F7FFFFF;
        tick();
        reset    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_class_idx", {28'd0, class_idx}, 32'd0);
        check("midrst_max_value", max_value, 32'd0);
        for (int n = 0; n < 4; n++) tick();
        begin_run(vecs[5], 1'b1);
        feed(vecs[5], 0, 9);
        wait_done();

        // Start mid-ACCUM restarts the count and drops the same-cycle sample.
        begin_run(big, 1'b0);
        feed(big, 0, 2);
        start    = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'h7F7FFFFF;
        sb.push_back({vecs[4].idx, vecs[4].mx});
        tick();
        start    = 1'b0;
        in_valid = 1'b0;
        check("restart_busy", {31'd0, busy}, 32'd1);
        check("restart_max_cleared", max_value, 32'd0);
        feed(vecs[4], 0, 9);
        wait_done();

        for (int n = 0; n < 3; n++) tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fc_argmax.md
FC_ARGMAX -- requirements
Module: fc_argmax

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning IEEE-754 single-precision word width; only 32 is supported.
REQ-002 SHALL have parameter NUM_CLASSES, default 10, meaning FC outputs per inference; legal range 2..2**IDX_WIDTH.
REQ-003 SHALL have parameter IDX_WIDTH, default 4, meaning class index width.
REQ-004 SHALL have port clk  input  1  single clock; all logic on the rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start  input  1  one-cycle pulse that begins a new inference.
REQ-007 SHALL have port in_valid  input  1  in_data carries one FC neuron output.
REQ-008 SHALL have port in_data  input  DATA_WIDTH  FC neuron output (output_fc of the FC PE).
REQ-009 SHALL have port in_ready  output  1  high only in ACCUM.
REQ-010 SHALL have port class_idx  output  IDX_WIDTH  index of the maximum value.
REQ-011 SHALL have port max_value  output  DATA_WIDTH  maximum value found.
REQ-012 SHALL have port busy  output  1  high in ACCUM.
REQ-013 SHALL have port done  output  1  one-cycle pulse when the result is valid.

Function
REQ-014 SHALL implement the FSM states IDLE, ACCUM and DONE.
REQ-015 SHALL move IDLE->ACCUM on start, clearing the sample counter, class_idx and max_value.
REQ-016 SHALL accept one sample per cycle in which in_valid and in_ready are both high.
REQ-017 SHALL load sample 0 unconditionally as the running max, with class_idx=0.
REQ-018 SHALL make sample k (k>=1) replace the running max only if it is strictly greater; ties keep the lower index.
REQ-019 SHALL compare floats as follows: positive beats negative; +0 equals -0; both positive, the larger bit pattern wins; both negative, the smaller bit pattern wins.
REQ-020 SHALL never let a NaN (exponent 0xFF, mantissa nonzero) replace the running max for k>=1.
REQ-021 SHALL move ACCUM->DONE on acceptance of sample NUM_CLASSES-1.
REQ-022 SHALL assert done for exactly the DONE cycle, which is the cycle after the last accept, then return to IDLE.
REQ-023 SHALL hold class_idx and max_value stable from done until the next start.
REQ-024 SHALL restart on a start received in ACCUM: counter and result cleared, state stays ACCUM, and any in_valid in that cycle is dropped.
REQ-025 SHALL ignore a start received in DONE; done still pulses.
REQ-026 SHALL ignore in_valid in IDLE and DONE.
REQ-027 SHALL treat the sample counter as IDX_WIDTH bits that never wrap past NUM_CLASSES-1.

Reset
REQ-028 SHALL, on reset, force the state to IDLE and the counter to 0.
REQ-029 SHALL drive these reset values: class_idx=0, max_value=0, done=0, busy=0, in_ready=0.
REQ-030 SHALL give reset priority over start and in_valid.
REQ-031 SHALL, on reset mid-ACCUM, discard the partial result with no done pulse.

Configuration
REQ-032 SHALL support macro FC_ARGMAX_RELU_EN.
REQ-033 SHALL, when FC_ARGMAX_RELU_EN is defined, replace each sample with sign bit set by 0x00000000 before comparison; max_value reports the clamped value.
REQ-034 SHALL, when FC_ARGMAX_RELU_EN is undefined, compare raw samples with no ReLU logic present.

Verification
REQ-035 SHALL cover: start, then 10 samples all 0x3F800000 except idx 6 = 0x40000000 -> done one cycle after the 10th accept, class_idx=6, max_value=0x40000000.
REQ-036 SHALL cover: all samples 0x3F000000 (tie) -> class_idx=0.
REQ-037 SHALL cover: all negative samples, idx 3 = 0xBF800000 and the rest 0xC0400000, with the macro off -> class_idx=3, max_value=0xBF800000; with FC_ARGMAX_RELU_EN -> class_idx=0, max_value=0x00000000.
REQ-038 SHALL cover: in_valid toggling every other cycle -> same result, and done exactly one cycle after the 10th accept.
REQ-039 SHALL cover: reset after sample 4, then start and 10 fresh samples -> no done before the new run; result reflects only the new samples.
REQ-040 SHALL cover: sample 2 = 0x7FC00000 (NaN), the others 0x3F800000 -> class_idx=0; start pulsed during ACCUM restarts with the counter at 0.
